// File: rtl/cpu_defs.sv
// Shared definitions for the 5-stage MIPS core.
//  - WB_*  : register-file writeback source select codes (3 bits)
//  - NPC_* : next-PC source select codes (2 bits)
//  - hc_state_t : hazard controller mult/div stall FSM encoding
package cpu_defs;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_RS  = 3'd1;
    localparam logic [2:0] WB_RAM = 3'd2;
    localparam logic [2:0] WB_HI  = 3'd3;
    localparam logic [2:0] WB_LO  = 3'd4;
    localparam logic [2:0] WB_PC8 = 3'd5;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    typedef enum logic [1:0] {
        HC_IDLE    = 2'd0,
        HC_MD_BUSY = 2'd1
    } hc_state_t;

endpackage

// File: rtl/md_stall_timer.sv
// Mult/div stall FSM. Enters MD_BUSY the cycle after md_start and stays there
// until md_done is seen or the cycle counter reaches MD_CYCLES.
// Ports:
//  clk      in  core clock
//  resetn   in  asynchronous active-low reset
//  md_start in  1-cycle pulse, mult/div issued (ignored while busy)
//  md_done  in  mult/div result valid (level)
//  md_busy  out FSM is in MD_BUSY
module md_stall_timer
    import cpu_defs::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic md_start,
    input  logic md_done,
    output logic md_busy
);

    hc_state_t          state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= HC_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter reads 1 in the first busy cycle, so the exit test at
    // MD_CYCLES bounds the freeze to exactly MD_CYCLES cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            HC_IDLE: begin
                if (md_start) begin
                    state_next = HC_MD_BUSY;
                    cnt_next   = CNT_W'(1);
                end
            end
            HC_MD_BUSY: begin
                if (md_done || (cnt_reg == CNT_W'(MD_CYCLES))) begin
                    state_next = HC_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = HC_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy = (state_reg == HC_MD_BUSY);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller. Compares the ID-stage sources with the
// EX and MEM destinations, drives the forwarding hazard selects, inserts a
// one-cycle load-use bubble, and freezes the pipe during mult/div.
// Ports:
//  clk, resetn                     clock, async active-low reset
//  id_rs/id_rt, id_r*_used         ID sources and whether they are read
//  ex_wreg/ex_we/ex_rf_wsel        EX destination, write enable, WB select
//  mem_wreg/mem_we/mem_rf_wsel     MEM destination, write enable, WB select
//  ex_md_start, md_done            mult/div issue pulse and completion
//  jmp                             taken branch/jump resolved in ID
//  id_ex_* / id_mem_*              forwarding hazard selects
//  pc_en, ifid_en, idex_en         pipeline register enables
//  idex_bubble, ifid_flush         NOP insert into ID-EX, IF-ID squash
//  md_busy                         mult/div freeze active
module hazard_ctrl
    import cpu_defs::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [4:0] ex_wreg,
    input  logic       ex_we,
    input  logic [2:0] ex_rf_wsel,
    input  logic [4:0] mem_wreg,
    input  logic       mem_we,
    input  logic [2:0] mem_rf_wsel,
    input  logic       ex_md_start,
    input  logic       md_done,
    input  logic       jmp,
    output logic       id_ex_hazard_mem,
    output logic       id_ex_rs_hazard_reg,
    output logic       id_ex_rt_hazard_reg,
    output logic       id_mem_rs_hazard_mem,
    output logic       id_mem_rs_hazard_reg,
    output logic       id_mem_rt_hazard_mem,
    output logic       id_mem_rt_hazard_reg,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       md_busy
);

    // Index 0 = rs, 1 = rt.
    logic [4:0] src      [2];
    logic [1:0] src_used;
    logic [1:0] ex_match, mem_match;
    logic [1:0] ex_reg_haz, mem_mem_haz, mem_reg_haz;
    logic       ex_is_load, mem_is_load, load_use;

    assign src[0]      = id_rs;
    assign src[1]      = id_rt;
    assign src_used    = {id_rt_used, id_rs_used};
    assign ex_is_load  = (ex_rf_wsel == WB_RAM);
    assign mem_is_load = (mem_rf_wsel == WB_RAM);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ex_match[gi]  = src_used[gi] & ex_we & (ex_wreg == src[gi])
                                 & (src[gi] != 5'd0);
            assign mem_match[gi] = src_used[gi] & mem_we & (mem_wreg == src[gi])
                                 & (src[gi] != 5'd0);
            // EX holds the younger value, so it masks any MEM match.
            assign ex_reg_haz[gi]  = resetn & ex_match[gi] & ~ex_is_load;
            assign mem_mem_haz[gi] = resetn & mem_match[gi] & ~ex_match[gi] & mem_is_load;
            assign mem_reg_haz[gi] = resetn & mem_match[gi] & ~ex_match[gi] & ~mem_is_load;
        end
    endgenerate

    assign load_use             = resetn & (|ex_match) & ex_is_load;
    assign id_ex_hazard_mem     = load_use;
    assign id_ex_rs_hazard_reg  = ex_reg_haz[0];
    assign id_ex_rt_hazard_reg  = ex_reg_haz[1];
    assign id_mem_rs_hazard_mem = mem_mem_haz[0];
    assign id_mem_rs_hazard_reg = mem_reg_haz[0];
    assign id_mem_rt_hazard_mem = mem_mem_haz[1];
    assign id_mem_rt_hazard_reg = mem_reg_haz[1];

    md_stall_timer #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_stall_timer (
        .clk      (clk),
        .resetn   (resetn),
        .md_start (ex_md_start),
        .md_done  (md_done),
        .md_busy  (md_busy)
    );

    // Priority: reset > mult/div freeze > load-use bubble > normal/jump flush.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = jmp;
        if (!resetn) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b0;
        end else if (md_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b0;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            // A stalled jump is resolved again once the bubble has gone through.
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import cpu_defs::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
    logic       id_rs_used, id_rt_used, ex_we, mem_we;
    logic [2:0] ex_rf_wsel, mem_rf_wsel;
    logic       ex_md_start, md_done, jmp;
    logic       id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg;
    logic       id_mem_rs_hazard_mem, id_mem_rs_hazard_reg;
    logic       id_mem_rt_hazard_mem, id_mem_rt_hazard_reg;
    logic       pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, md_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_wreg(ex_wreg), .ex_we(ex_we), .ex_rf_wsel(ex_rf_wsel),
        .mem_wreg(mem_wreg), .mem_we(mem_we), .mem_rf_wsel(mem_rf_wsel),
        .ex_md_start(ex_md_start), .md_done(md_done), .jmp(jmp),
        .id_ex_hazard_mem(id_ex_hazard_mem),
        .id_ex_rs_hazard_reg(id_ex_rs_hazard_reg),
        .id_ex_rt_hazard_reg(id_ex_rt_hazard_reg),
        .id_mem_rs_hazard_mem(id_mem_rs_hazard_mem),
        .id_mem_rs_hazard_reg(id_mem_rs_hazard_reg),
        .id_mem_rt_hazard_mem(id_mem_rt_hazard_mem),
        .id_mem_rt_hazard_reg(id_mem_rt_hazard_reg),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .md_busy(md_busy)
    );

    // haz = {ex_mem, ex_rs_reg, ex_rt_reg, mem_rs_mem, mem_rs_reg, mem_rt_mem, mem_rt_reg}
    // ctl = {pc_en, ifid_en, idex_en, idex_bubble, ifid_flush}
    function automatic logic [6:0] haz_vec();
        return {id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg,
                id_mem_rs_hazard_mem, id_mem_rs_hazard_reg,
                id_mem_rt_hazard_mem, id_mem_rt_hazard_reg};
    endfunction

    function automatic logic [4:0] ctl_vec();
        return {pc_en, ifid_en, idex_en, idex_bubble, ifid_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic       rs_u, rt_u;
        logic [4:0] exw;
        logic       exwe;
        logic [2:0] exsel;
        logic [4:0] mw;
        logic       mwe;
        logic [2:0] msel;
        logic       j;
        logic [6:0] haz;
        logic [4:0] ctl;
    } vec_t;

    vec_t vt [13];

    task automatic drive(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rs_u; id_rt_used = v.rt_u;
        ex_wreg = v.exw; ex_we = v.exwe; ex_rf_wsel = v.exsel;
        mem_wreg = v.mw; mem_we = v.mwe; mem_rf_wsel = v.msel; jmp = v.j;
    endtask

    task automatic quiet();
        id_rs = 5'd1; id_rt = 5'd2; id_rs_used = 1'b1; id_rt_used = 1'b1;
        ex_wreg = 5'd20; ex_we = 1'b0; ex_rf_wsel = WB_ALU;
        mem_wreg = 5'd21; mem_we = 1'b0; mem_rf_wsel = WB_ALU; jmp = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //      rs     rt    rsu  rtu   exw   exwe  exsel   mw    mwe   msel   j     haz          ctl
        vt[0]  = '{5'd3, 5'd4, 1, 1, 5'd3, 1, WB_ALU, 5'd0, 0, WB_ALU, 0, 7'b0100000, 5'b11100};
        vt[1]  = '{5'd1, 5'd5, 1, 1, 5'd5, 1, WB_RAM, 5'd0, 0, WB_ALU, 0, 7'b1000000, 5'b00110};
        vt[2]  = '{5'd1, 5'd5, 1, 1, 5'd9, 0, WB_ALU, 5'd5, 1, WB_RAM, 0, 7'b0000010, 5'b11100};
        vt[3]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, WB_ALU, 5'd0, 1, WB_RAM, 0, 7'b0000000, 5'b11100};
        vt[4]  = '{5'd7, 5'd1, 1, 1, 5'd7, 1, WB_ALU, 5'd7, 1, WB_ALU, 0, 7'b0100000, 5'b11100};
        vt[5]  = '{5'd7, 5'd1, 0, 1, 5'd7, 1, WB_RAM, 5'd7, 1, WB_ALU, 0, 7'b0000000, 5'b11100};
        vt[6]  = '{5'd9, 5'd1, 1, 1, 5'd9, 0, WB_ALU, 5'd9, 1, WB_ALU, 0, 7'b0000100, 5'b11100};
        vt[7]  = '{5'd4, 5'd4, 1, 1, 5'd8, 1, WB_ALU, 5'd4, 1, WB_RAM, 0, 7'b0001010, 5'b11100};
        vt[8]  = '{5'd2, 5'd2, 1, 1, 5'd2, 1, WB_ALU, 5'd2, 1, WB_RAM, 0, 7'b0110000, 5'b11100};
        vt[9]  = '{5'd6, 5'd1, 1, 1, 5'd6, 1, WB_RAM, 5'd0, 0, WB_ALU, 1, 7'b1000000, 5'b00110};
        vt[10] = '{5'd1, 5'd2, 1, 1, 5'd9, 1, WB_ALU, 5'd9, 1, WB_ALU, 1, 7'b0000000, 5'b11101};
        vt[11] = '{5'd8, 5'd9, 1, 1, 5'd8, 1, WB_ALU, 5'd9, 1, WB_RAM, 0, 7'b0100010, 5'b11100};
        vt[12] = '{5'd11, 5'd12, 1, 1, 5'd11, 1, WB_RAM, 5'd12, 1, WB_ALU, 0, 7'b1000001, 5'b00110};

        resetn = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
        drive(vt[0]);
        #3;
        chk("reset_haz", 32'(haz_vec()), 32'h0);
        chk("reset_ctl", 32'(ctl_vec()), 32'(5'b00010));
        chk("reset_busy", 32'(md_busy), 32'h0);
        next_cycle();
        resetn = 1'b1;

        // Combinational vectors, FSM idle.
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(vt[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_haz", i), 32'(haz_vec()), 32'(vt[i].haz));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_vec()), 32'(vt[i].ctl));
        end

        // Load-use, then the load advances to MEM behind the bubble.
        next_cycle();
        quiet(); id_rt = 5'd5; ex_wreg = 5'd5; ex_we = 1'b1; ex_rf_wsel = WB_RAM;
        @(negedge clk);
        chk("lu_stall_ctl", 32'(ctl_vec()), 32'(5'b00110));
        next_cycle();
        ex_we = 1'b0; ex_wreg = 5'd0; ex_rf_wsel = WB_ALU;
        mem_wreg = 5'd5; mem_we = 1'b1; mem_rf_wsel = WB_RAM;
        @(negedge clk);
        chk("lu_mem_haz", 32'(haz_vec()), 32'(7'b0000010));
        chk("lu_mem_ctl", 32'(ctl_vec()), 32'(5'b11100));

        // Mult/div finished by md_done in busy cycle 10.
        next_cycle();
        quiet(); ex_md_start = 1'b1;
        @(negedge clk);
        chk("md_start_busy", 32'(md_busy), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            ex_md_start = (k == 3);      // re-issue while busy is ignored
            md_done     = (k == 10);
            jmp         = (k == 5);
            if (k == 6) begin            // load-use pattern, overridden by freeze
                id_rs = 5'd9; ex_wreg = 5'd9; ex_we = 1'b1; ex_rf_wsel = WB_RAM;
            end
            if (k == 7) begin
                ex_we = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("md_c%0d_busy", k), 32'(md_busy), 32'h1);
            chk($sformatf("md_c%0d_ctl", k), 32'(ctl_vec()), 32'(5'b00000));
        end
        next_cycle();
        md_done = 1'b0; jmp = 1'b0; ex_md_start = 1'b0;
        @(negedge clk);
        chk("md_done_release_busy", 32'(md_busy), 32'h0);
        chk("md_done_release_ctl", 32'(ctl_vec()), 32'(5'b11100));

        // Mult/div with no md_done: timeout after 32 busy cycles.
        begin
            int busy_cnt;
            int guard;
            busy_cnt = 0;
            guard = 0;
            next_cycle();
            ex_md_start = 1'b1;
            next_cycle();
            ex_md_start = 1'b0;
            @(negedge clk);
            while (md_busy && guard < 40) begin
                busy_cnt++;
                guard++;
                @(negedge clk);
            end
            chk("md_timeout_cycles", 32'(busy_cnt), 32'd32);
            chk("md_timeout_ctl", 32'(ctl_vec()), 32'(5'b11100));
        end

        // Reset asserted during busy cycle 5.
        next_cycle();
        ex_md_start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            ex_md_start = 1'b0;
        end
        @(negedge clk);
        chk("rst_mid_pre_busy", 32'(md_busy), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(md_busy), 32'h0);
        chk("rst_mid_ctl", 32'(ctl_vec()), 32'(5'b00010));
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_rel_busy", 32'(md_busy), 32'h0);
        chk("rst_rel_ctl", 32'(ctl_vec()), 32'(5'b11100));
        next_cycle();
        @(negedge clk);
        chk("rst_rel2_busy", 32'(md_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

endmodule
